// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO with trigger-level, overrun and 16550-style character timeout.
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN builds the timeout counter; otherwise timeout_o is tied low.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic [7:0]               in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [7:0]               out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    input  logic [15:0]              cfg_div_i,
    input  logic [1:0]               cfg_trig_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     trig_o,
    output logic                     timeout_o,
    output logic                     overrun_o,
    input  logic                     overrun_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [LW-1:0] level_r;
    logic          overrun_r;
    logic          in_ready_r;

    logic          push_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [LW-1:0] level_nxt_s;
    logic [LW-1:0] trig_lvl_s;

    // Handshake decode; a same-cycle pop frees the slot a push into a full FIFO needs
    always_comb begin
        push_s  = in_valid_i && in_ready_r;
        pop_s   = (level_r != '0) && out_ready_i && !clr_i;
        wr_en_s = push_s && !clr_i && ((level_r != FULL_LVL) || pop_s);
        drop_s  = push_s && !clr_i && (level_r == FULL_LVL) && !pop_s;
    end

    // Next fill level
    always_comb begin
        level_nxt_s = level_r;
        if (clr_i) begin
            level_nxt_s = '0;
        end else if (wr_en_s && !pop_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (!wr_en_s && pop_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Storage, pointers and level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wptr_r  <= '0;
            rptr_r  <= '0;
            level_r <= '0;
        end else if (clr_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            level_r <= '0;
        end else begin
            if (wr_en_s) begin
                mem_r[wptr_r] <= in_data_i;
                wptr_r        <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            level_r <= level_nxt_s;
        end
    end

    // Receiver is never stalled once out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= 1'b1;
        end
    end

    // Sticky overrun; software clear wins over a same-cycle drop, flush leaves it alone
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_r <= 1'b0;
        end else if (overrun_clr_i) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Trigger threshold select
    always_comb begin
        trig_lvl_s = LW'(1);
        case (cfg_trig_i)
            2'b00:   trig_lvl_s = LW'(1);
            2'b01:   trig_lvl_s = LW'(4);
            2'b10:   trig_lvl_s = LW'(8);
            2'b11:   trig_lvl_s = LW'(14);
            default: trig_lvl_s = LW'(1);
        endcase
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [25:0] tmo_cnt_r;
    logic [25:0] tmo_thr_s;

    // Four character times of 10 bits at 16x oversampling
    assign tmo_thr_s = 26'(cfg_div_i) * 26'd640;

    // Idle counter, saturating at the threshold while characters sit unread
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_r <= 26'd0;
        end else if (push_s || pop_s || clr_i || (level_r == '0)) begin
            tmo_cnt_r <= 26'd0;
        end else if (tmo_cnt_r != tmo_thr_s) begin
            tmo_cnt_r <= tmo_cnt_r + 26'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign timeout_o = (tmo_cnt_r == tmo_thr_s) && (level_r != '0) && (cfg_div_i != 16'd0);
`else
    logic unused_div_s;
    assign unused_div_s = ^cfg_div_i;
    assign timeout_o    = 1'b0;
`endif

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = (level_r != '0);
    assign out_data_o  = mem_r[rptr_r];
    assign level_o     = level_r;
    assign overrun_o   = overrun_r;
    assign trig_o      = (level_r >= trig_lvl_s);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed test-plan scenarios followed by randomized traffic.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       clr_i = 1'b0;
    logic [7:0] in_data_i = 8'h00;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [15:0] cfg_div_i = 16'd1;
    logic [1:0] cfg_trig_i = 2'b00;
    logic [4:0] level_o;
    logic       trig_o;
    logic       timeout_o;
    logic       overrun_o;
    logic       overrun_clr_i = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .cfg_div_i(cfg_div_i), .cfg_trig_i(cfg_trig_i), .level_o(level_o),
        .trig_o(trig_o), .timeout_o(timeout_o), .overrun_o(overrun_o),
        .overrun_clr_i(overrun_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents queue (scoreboard), fill level, sticky flag, idle cycle count
    logic [7:0] exp_q[$];
    int mdl_level = 0;
    int mdl_ovr   = 0;
    int mdl_rdy   = 0;
    int mdl_idle  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_level = 0;
        mdl_ovr   = 0;
        mdl_rdy   = 0;
        mdl_idle  = 0;
    endtask

    // Apply the rules to the inputs that were present at the edge just taken
    task automatic model_update();
        int old_lvl, thr;
        bit pop, push, acc;
        if (rst_i) begin
            model_reset();
        end else begin
            old_lvl = mdl_level;
            thr     = 640 * int'(cfg_div_i);
            push    = in_valid_i && (mdl_rdy != 0);
            mdl_rdy = 1;
            if (clr_i) begin
                exp_q.delete();
                mdl_level = 0;
                mdl_idle  = 0;
                if (overrun_clr_i) mdl_ovr = 0;
            end else begin
                pop = out_ready_i && (old_lvl > 0);
                acc = push && ((old_lvl < DEPTH) || pop);
                if (acc) exp_q.push_back(in_data_i);
                mdl_level = old_lvl + int'(acc) - int'(pop);
                if (overrun_clr_i) mdl_ovr = 0;
                else if (push && !acc) mdl_ovr = 1;
                if (push || pop || old_lvl == 0) mdl_idle = 0;
                else if (mdl_idle < thr) mdl_idle++;
            end
        end
    endtask

    function automatic int trig_thr(input logic [1:0] sel);
        case (sel)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 14;
        endcase
    endfunction

    // Monitor: compares status every cycle and scores each pop against the queue head
    always @(negedge clk_i) begin
        int exp_to;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        exp_to = (cfg_div_i != 16'd0) && (mdl_level != 0) && (mdl_idle == 640 * int'(cfg_div_i));
`else
        exp_to = 0;
`endif
        chk("in_ready", int'(in_ready_o), mdl_rdy);
        chk("out_valid", int'(out_valid_o), int'(mdl_level != 0));
        chk("level", int'(level_o), mdl_level);
        chk("trig", int'(trig_o), int'(mdl_level >= trig_thr(cfg_trig_i)));
        chk("overrun", int'(overrun_o), mdl_ovr);
        chk("timeout", int'(timeout_o), exp_to);
        if (!rst_i && !clr_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", exp_q.size(), 1);
            end else begin
                chk("pop_data", int'(out_data_o), int'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input logic v, input logic [7:0] d, input logic r,
                        input logic c, input logic oc);
        in_valid_i    = v;
        in_data_i     = d;
        out_ready_i   = r;
        clr_i         = c;
        overrun_clr_i = oc;
        @(posedge clk_i);
        #1;
        model_update();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_n(input int n, input int base);
        for (int k = 0; k < n; k++) tick(1'b1, 8'(base + k), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && mdl_level != 0; k++) tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drain_done", int'(level_o), 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        model_reset();
        idle(2);
        chk("rst_data", int'(out_data_o), 0);
        rst_i = 1'b0;
        idle(1);
    endtask

    initial begin
        int first_to, seen_to, bias;
        model_reset();
        do_reset();

        // First post-reset push lands one cycle later
        chk("ready_after_rst", int'(in_ready_o), 1);
        tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5_valid", int'(out_valid_o), 1);
        chk("a5_data", int'(out_data_o), 8'hA5);
        chk("a5_level", int'(level_o), 1);
        drain();

        // Fill, overflow, drain in order, then clear the flag
        push_n(16, 8'h00);
        tick(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        chk("full_level", int'(level_o), 16);
        chk("full_overrun", int'(overrun_o), 1);
        drain();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovr_cleared", int'(overrun_o), 0);

        // Full with simultaneous push and pop
        push_n(16, 8'h20);
        tick(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("pp_level", int'(level_o), 16);
        chk("pp_overrun", int'(overrun_o), 0);
        drain();

        // Trigger thresholds
        cfg_trig_i = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            tick(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
            chk("trig4", int'(trig_o), int'(k == 4));
        end
        cfg_trig_i = 2'b11;
        for (int k = 5; k <= 14; k++) begin
            tick(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
            chk("trig14", int'(trig_o), int'(k == 14));
        end
        drain();
        cfg_trig_i = 2'b00;

        // Flush with level 7 and overrun pending; push in the flush cycle is dropped
        push_n(17, 8'h40);
        for (int k = 0; k < 9; k++) tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre_clr_level", int'(level_o), 7);
        tick(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        chk("clr_level", int'(level_o), 0);
        chk("clr_valid", int'(out_valid_o), 0);
        chk("clr_overrun", int'(overrun_o), 1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Character timeout with divisor 1, then disabled with divisor 0
        cfg_div_i = 16'd1;
        tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        first_to = 0;
        for (int k = 1; k <= 700; k++) begin
            idle(1);
            if (timeout_o && first_to == 0) first_to = k;
        end
`ifdef UART_RX_FIFO_TIMEOUT_EN
        chk("timeout_cycles", first_to, 640);
`else
        chk("timeout_cycles", first_to, 0);
`endif
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("timeout_cleared", int'(timeout_o), 0);
        cfg_div_i = 16'd0;
        tick(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        seen_to = 0;
        for (int k = 0; k < 700; k++) begin
            idle(1);
            if (timeout_o) seen_to++;
        end
        chk("div0_no_timeout", seen_to, 0);
        drain();
        cfg_div_i = 16'd1;

        // Randomized traffic with alternating fill/drain bias and one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (i % 200 == 0) cfg_trig_i = 2'($urandom_range(0, 3));
            bias = ((i / 300) % 2 == 0) ? 4 : 1;
            tick($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, bias) == 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 31) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
